// File: rtl/alu_ctrl_pkg.sv
// Shared encodings for the multicycle ALU control sequencer: ALU ops, MIPS
// opcode/funct values, alu_src_b selects, sequencer states and instruction classes.
package alu_ctrl_pkg;

   localparam logic [3:0] ALU_AND = 4'b0000;
   localparam logic [3:0] ALU_OR  = 4'b0001;
   localparam logic [3:0] ALU_ADD = 4'b0010;
   localparam logic [3:0] ALU_SUB = 4'b0110;
   localparam logic [3:0] ALU_SLT = 4'b0111;
   localparam logic [3:0] ALU_NOR = 4'b1100;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;

   localparam logic [5:0] FN_ADD = 6'h20;
   localparam logic [5:0] FN_SUB = 6'h22;
   localparam logic [5:0] FN_AND = 6'h24;
   localparam logic [5:0] FN_OR  = 6'h25;
   localparam logic [5:0] FN_NOR = 6'h27;
   localparam logic [5:0] FN_SLT = 6'h2A;

   localparam logic [1:0] SRCB_RT      = 2'b00;
   localparam logic [1:0] SRCB_FOUR    = 2'b01;
   localparam logic [1:0] SRCB_IMM     = 2'b10;
   localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

   typedef enum logic [3:0] {
      S_FETCH,
      S_DECODE,
      S_EXEC_R,
      S_EXEC_I,
      S_ALU_WB,
      S_MEM_ADDR,
      S_MEM_RD,
      S_MEM_WR,
      S_MEM_WB,
      S_BRANCH,
      S_ILLEGAL
   } state_e;

   typedef enum logic [2:0] {
      CLS_R,
      CLS_ADDI,
      CLS_LW,
      CLS_SW,
      CLS_BEQ,
      CLS_ILL
   } instr_cls_e;

endpackage

// File: rtl/alu_ctrl_fsm_alu_funct_dec.sv
// Combinational instruction decoder: opcode + funct to instruction class,
// R-type ALU op and legality.
module alu_funct_dec
   import alu_ctrl_pkg::*;
(
   input  logic [5:0]  opcode_i,
   input  logic [5:0]  funct_i,
   output instr_cls_e  cls_o,
   output logic [3:0]  alu_op_o,
   output logic        legal_o
);

   always_comb begin
      cls_o    = CLS_ILL;
      alu_op_o = ALU_ADD;
      legal_o  = 1'b0;
      case (opcode_i)
         OP_RTYPE: begin
            cls_o   = CLS_R;
            legal_o = 1'b1;
            case (funct_i)
               FN_ADD:  alu_op_o = ALU_ADD;
               FN_SUB:  alu_op_o = ALU_SUB;
               FN_AND:  alu_op_o = ALU_AND;
               FN_OR:   alu_op_o = ALU_OR;
               FN_NOR:  alu_op_o = ALU_NOR;
               FN_SLT:  alu_op_o = ALU_SLT;
               default: begin
                  cls_o   = CLS_ILL;
                  legal_o = 1'b0;
               end
            endcase
         end
         OP_ADDI: begin cls_o = CLS_ADDI; legal_o = 1'b1; end
         OP_LW:   begin cls_o = CLS_LW;   legal_o = 1'b1; end
         OP_SW:   begin cls_o = CLS_SW;   legal_o = 1'b1; end
         OP_BEQ:  begin cls_o = CLS_BEQ;  legal_o = 1'b1; end
         default: ;
      endcase
   end

endmodule

// File: rtl/alu_ctrl_fsm.sv
// Multicycle MIPS control sequencer issuing ALU/regfile/PC/memory strobes.
// Optional macro ALU_CTRL_PERF_CNT_EN adds retired/illegal instruction counters.
module alu_ctrl_fsm
   import alu_ctrl_pkg::*;
#(
   parameter int MEM_TIMEOUT = 0,
   parameter int TMO_W       = 8
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        instr_valid,
   output logic        instr_ready,
   input  logic [31:0] instr,
   input  logic        alu_zero,
   input  logic        mem_ready,
   output logic [3:0]  alu_op,
   output logic        alu_src_a,
   output logic [1:0]  alu_src_b,
   output logic        ir_write,
   output logic        pc_write,
   output logic        pc_src,
   output logic        reg_write,
   output logic        reg_dst,
   output logic        mem_to_reg,
   output logic        mem_read,
   output logic        mem_write,
   output logic        illegal
`ifdef ALU_CTRL_PERF_CNT_EN
   ,
   output logic [31:0] retired_cnt,
   output logic [15:0] illegal_cnt
`endif
);

   // Timeout fires on the cycle the count would reach MEM_TIMEOUT, so the strobe is held MEM_TIMEOUT cycles.
   localparam logic [TMO_W-1:0] TMO_LAST = (MEM_TIMEOUT == 0) ? '0 : TMO_W'(MEM_TIMEOUT - 1);

   state_e            state_q, state_d;
   logic              run_q;
   logic [31:0]       ir_q;
   logic [TMO_W-1:0]  tmo_q, tmo_d;

   instr_cls_e        dec_cls;
   logic [3:0]        dec_alu_op;
   logic              dec_legal;
   logic              hs, mem_tmo, unused_ir_bits;

   logic [3:0] alu_op_c;
   logic       src_a_c, ir_write_c, pc_write_c, pc_src_c, reg_write_c, reg_dst_c;
   logic [1:0] src_b_c;
   logic       mem_to_reg_c, mem_read_c, mem_write_c, illegal_c, instr_ready_c;

   alu_funct_dec u_dec (
      .opcode_i (ir_q[31:26]),
      .funct_i  (ir_q[5:0]),
      .cls_o    (dec_cls),
      .alu_op_o (dec_alu_op),
      .legal_o  (dec_legal)
   );

   assign unused_ir_bits = ^ir_q[25:6];
   assign hs      = run_q & (state_q == S_FETCH) & instr_valid;
   assign mem_tmo = (MEM_TIMEOUT != 0) && !mem_ready && (tmo_q == TMO_LAST);
   assign tmo_d   = ((state_q == S_MEM_RD || state_q == S_MEM_WR) && !mem_ready) ? tmo_q + 1'b1 : '0;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_FETCH;
         run_q   <= 1'b0;
         ir_q    <= '0;
         tmo_q   <= '0;
      end else begin
         state_q <= state_d;
         run_q   <= 1'b1;
         tmo_q   <= tmo_d;
         if (hs) ir_q <= instr;
      end
   end

   always_comb begin
      state_d       = state_q;
      alu_op_c      = ALU_ADD;
      src_a_c       = 1'b0;
      src_b_c       = SRCB_RT;
      ir_write_c    = 1'b0;
      pc_write_c    = 1'b0;
      pc_src_c      = 1'b0;
      reg_write_c   = 1'b0;
      reg_dst_c     = 1'b0;
      mem_to_reg_c  = 1'b0;
      mem_read_c    = 1'b0;
      mem_write_c   = 1'b0;
      illegal_c     = 1'b0;
      instr_ready_c = 1'b0;
      case (state_q)
         S_FETCH: begin
            instr_ready_c = 1'b1;
            src_b_c       = SRCB_FOUR;
            ir_write_c    = hs;
            pc_write_c    = hs;
            if (hs) state_d = S_DECODE;
         end
         S_DECODE: begin
            src_b_c = SRCB_IMM_SH2;
            if (!dec_legal) state_d = S_ILLEGAL;
            else begin
               case (dec_cls)
                  CLS_R:          state_d = S_EXEC_R;
                  CLS_ADDI:       state_d = S_EXEC_I;
                  CLS_LW, CLS_SW: state_d = S_MEM_ADDR;
                  CLS_BEQ:        state_d = S_BRANCH;
                  default:        state_d = S_ILLEGAL;
               endcase
            end
         end
         S_EXEC_R: begin
            src_a_c  = 1'b1;
            alu_op_c = dec_alu_op;
            state_d  = S_ALU_WB;
         end
         S_EXEC_I: begin
            src_a_c = 1'b1;
            src_b_c = SRCB_IMM;
            state_d = S_ALU_WB;
         end
         S_ALU_WB: begin
            reg_write_c = 1'b1;
            reg_dst_c   = (dec_cls == CLS_R);
            state_d     = S_FETCH;
         end
         S_MEM_ADDR: begin
            src_a_c = 1'b1;
            src_b_c = SRCB_IMM;
            state_d = (dec_cls == CLS_LW) ? S_MEM_RD : S_MEM_WR;
         end
         S_MEM_RD: begin
            mem_read_c = 1'b1;
            if (mem_ready)    state_d = S_MEM_WB;
            else if (mem_tmo) state_d = S_ILLEGAL;
         end
         S_MEM_WR: begin
            mem_write_c = 1'b1;
            if (mem_ready)    state_d = S_FETCH;
            else if (mem_tmo) state_d = S_ILLEGAL;
         end
         S_MEM_WB: begin
            reg_write_c  = 1'b1;
            mem_to_reg_c = 1'b1;
            state_d      = S_FETCH;
         end
         S_BRANCH: begin
            src_a_c    = 1'b1;
            alu_op_c   = ALU_SUB;
            pc_src_c   = 1'b1;
            pc_write_c = alu_zero;
            state_d    = S_FETCH;
         end
         S_ILLEGAL: begin
            illegal_c = 1'b1;
            state_d   = S_FETCH;
         end
         default: state_d = S_FETCH;
      endcase
   end

   // run_q is cleared asynchronously, so every strobe drops the moment rst_n falls.
   assign alu_op      = run_q ? alu_op_c : ALU_ADD;
   assign alu_src_a   = run_q & src_a_c;
   assign alu_src_b   = run_q ? src_b_c : SRCB_RT;
   assign ir_write    = run_q & ir_write_c;
   assign pc_write    = run_q & pc_write_c;
   assign pc_src      = run_q & pc_src_c;
   assign reg_write   = run_q & reg_write_c;
   assign reg_dst     = run_q & reg_dst_c;
   assign mem_to_reg  = run_q & mem_to_reg_c;
   assign mem_read    = run_q & mem_read_c;
   assign mem_write   = run_q & mem_write_c;
   assign illegal     = run_q & illegal_c;
   assign instr_ready = run_q & instr_ready_c;

`ifdef ALU_CTRL_PERF_CNT_EN
   logic [31:0] retired_cnt_q;
   logic [15:0] illegal_cnt_q;
   logic        retire;

   assign retire = run_q && (state_d == S_FETCH) &&
                   (state_q inside {S_ALU_WB, S_MEM_WB, S_MEM_WR, S_BRANCH});

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         retired_cnt_q <= '0;
         illegal_cnt_q <= '0;
      end else begin
         if (retire)  retired_cnt_q <= retired_cnt_q + 32'd1;
         if (illegal) illegal_cnt_q <= illegal_cnt_q + 16'd1;
      end
   end

   assign retired_cnt = retired_cnt_q;
   assign illegal_cnt = illegal_cnt_q;
`endif

endmodule

// File: tb/tb_alu_ctrl_fsm.sv
// Scoreboard bench for alu_ctrl_fsm: per-cycle expected strobe vectors are queued
// at issue time and popped by a monitor from the handshake cycle onward.
module tb_alu_ctrl_fsm;
   import alu_ctrl_pkg::*;

   typedef logic [16:0] vec_t;
   typedef struct {
      vec_t  e;
      vec_t  m;
      string nm;
      bit    last;
   } rec_t;

   localparam logic [6:0] T_IRW = 7'b1000000;
   localparam logic [6:0] T_PCW = 7'b0100000;
   localparam logic [6:0] T_RW  = 7'b0010000;
   localparam logic [6:0] T_MR  = 7'b0001000;
   localparam logic [6:0] T_MW  = 7'b0000100;
   localparam logic [6:0] T_IL  = 7'b0000010;
   localparam logic [6:0] T_RDY = 7'b0000001;

   localparam vec_t M_STB = {4'h0, 1'b0, 2'b00, 3'b000, 7'h7F};
   localparam vec_t M_ALU = {4'hF, 1'b1, 2'b11, 3'b000, 7'h7F};
   localparam vec_t M_PC  = {4'hF, 1'b1, 2'b11, 3'b100, 7'h7F};
   localparam vec_t M_WB  = {4'h0, 1'b0, 2'b00, 3'b011, 7'h7F};
   localparam vec_t RST_V = {ALU_ADD, 13'd0};

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        instr_valid = 1'b0;
   logic [31:0] instr = '0;
   logic        alu_zero = 1'b0;
   logic        mem_ready = 1'b0;
   logic        instr_ready, alu_src_a, ir_write, pc_write, pc_src, reg_write, reg_dst;
   logic        mem_to_reg, mem_read, mem_write, illegal;
   logic [3:0]  alu_op;
   logic [1:0]  alu_src_b;
`ifdef ALU_CTRL_PERF_CNT_EN
   logic [31:0] retired_cnt;
   logic [15:0] illegal_cnt;
`endif

   int   checks = 0;
   int   failures = 0;
   rec_t sbq[$];
   bit   active = 1'b0;

   alu_ctrl_fsm #(.MEM_TIMEOUT(4), .TMO_W(8)) dut (
      .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid), .instr_ready(instr_ready),
      .instr(instr), .alu_zero(alu_zero), .mem_ready(mem_ready), .alu_op(alu_op),
      .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .ir_write(ir_write), .pc_write(pc_write),
      .pc_src(pc_src), .reg_write(reg_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
      .mem_read(mem_read), .mem_write(mem_write), .illegal(illegal)
`ifdef ALU_CTRL_PERF_CNT_EN
      , .retired_cnt(retired_cnt), .illegal_cnt(illegal_cnt)
`endif
   );

   always #5 clk = ~clk;

   function automatic vec_t cur_vec();
      return {alu_op, alu_src_a, alu_src_b, pc_src, reg_dst, mem_to_reg,
              ir_write, pc_write, reg_write, mem_read, mem_write, illegal, instr_ready};
   endfunction

   function automatic vec_t mkv(logic [3:0] op, logic sa, logic [1:0] sb, logic ps,
                                logic rd, logic m2r, logic [6:0] st);
      return {op, sa, sb, ps, rd, m2r, st};
   endfunction

   task automatic push(string nm, vec_t e, vec_t m, bit last);
      rec_t r;
      r.e = e; r.m = m; r.nm = nm; r.last = last;
      sbq.push_back(r);
   endtask

   task automatic p_hs();     push("fetch_handshake", mkv(ALU_ADD, 1'b0, 2'b01, 1'b0, 1'b0, 1'b0, T_IRW | T_PCW | T_RDY), M_PC, 1'b0); endtask
   task automatic p_dec();    push("decode",   mkv(ALU_ADD, 1'b0, 2'b11, 1'b0, 1'b0, 1'b0, 7'd0), M_ALU, 1'b0); endtask
   task automatic p_exr(input logic [3:0] op); push("exec_r", mkv(op, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 7'd0), M_ALU, 1'b0); endtask
   task automatic p_exi();    push("exec_i",   mkv(ALU_ADD, 1'b1, 2'b10, 1'b0, 1'b0, 1'b0, 7'd0), M_ALU, 1'b0); endtask
   task automatic p_maddr();  push("mem_addr", mkv(ALU_ADD, 1'b1, 2'b10, 1'b0, 1'b0, 1'b0, 7'd0), M_ALU, 1'b0); endtask
   task automatic p_awb(input logic rd); push("alu_wb", mkv(ALU_ADD, 1'b0, 2'b00, 1'b0, rd, 1'b0, T_RW), M_WB, 1'b0); endtask
   task automatic p_mrd();    push("mem_rd",   mkv(ALU_ADD, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, T_MR), M_STB, 1'b0); endtask
   task automatic p_mwr();    push("mem_wr",   mkv(ALU_ADD, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, T_MW), M_STB, 1'b0); endtask
   task automatic p_mwb();    push("mem_wb",   mkv(ALU_ADD, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1, T_RW), M_WB, 1'b0); endtask
   task automatic p_br(input logic z); push("branch", mkv(ALU_SUB, 1'b1, 2'b00, 1'b1, 1'b0, 1'b0, z ? T_PCW : 7'd0), M_PC, 1'b0); endtask
   task automatic p_ill();    push("illegal",  mkv(ALU_ADD, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, T_IL), M_STB, 1'b0); endtask
   task automatic p_fet();    push("fetch_return", mkv(ALU_ADD, 1'b0, 2'b01, 1'b0, 1'b0, 1'b0, T_RDY), M_PC, 1'b1); endtask

   task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) begin @(posedge clk); #1; end
   endtask

   // Present iw until the sequencer accepts it; returns 1 ns after the accepting edge.
   task automatic hs(input logic [31:0] iw);
      bit ok;
      ok = 1'b0;
      instr = iw;
      instr_valid = 1'b1;
      for (int n = 0; n < 20 && !ok; n++) begin
         @(negedge clk);
         ok = instr_ready;
      end
      if (!ok) begin
         checks++; failures++;
         $display("FAIL handshake_timeout actual=no_ready required=ready");
         instr_valid = 1'b0;
      end else begin
         @(posedge clk); #1;
         instr_valid = 1'b0;
      end
   endtask

   always @(negedge clk) begin
      rec_t r;
      vec_t cur;
      if (!rst_n) begin
         active = 1'b0;
         sbq.delete();
      end else if (active || (instr_valid && instr_ready)) begin
         active = 1'b1;
         checks++;
         if (sbq.size() == 0) begin
            failures++;
            active = 1'b0;
            $display("FAIL scoreboard_underflow actual=%05h required=no_activity", cur_vec());
         end else begin
            r = sbq.pop_front();
            cur = cur_vec();
            if (((cur ^ r.e) & r.m) != '0) begin
               failures++;
               $display("FAIL %s actual=%05h required=%05h care=%05h", r.nm, cur, r.e, r.m);
            end
            if (r.last) active = 1'b0;
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog actual=running required=finished");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [5:0] fns [6];
      logic [3:0] ops [6];
      fns = '{FN_ADD, FN_SUB, FN_AND, FN_OR, FN_NOR, FN_SLT};
      ops = '{ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_NOR, ALU_SLT};

      repeat (3) @(posedge clk);
      #1 chk("reset_outputs", 32'(cur_vec()), 32'(RST_V));
      @(negedge clk); #1 rst_n = 1'b1;
      #1 chk("first_cycle_after_reset", 32'(cur_vec()), 32'(RST_V));
      @(posedge clk); #1 chk("ready_after_run", 32'(instr_ready), 32'd1);

      // add, with valid held high (different word) while busy: must not be consumed
      p_hs(); p_dec(); p_exr(ALU_ADD); p_awb(1'b1); p_fet();
      hs(32'h0022_1820);
      instr = 32'hFC00_0000; instr_valid = 1'b1;
      tick(2);
      instr_valid = 1'b0;
      tick(2);

      for (int i = 0; i < 6; i++) begin
         p_hs(); p_dec(); p_exr(ops[i]); p_awb(1'b1); p_fet();
         hs({6'h00, 5'd1, 5'd2, 5'd3, 5'd0, fns[i]});
         tick(4);
      end

      p_hs(); p_dec(); p_ill(); p_fet();
      hs(32'h0022_1803);
      tick(3);

      p_hs(); p_dec(); p_ill(); p_fet();
      hs(32'hFC22_0005);
      tick(3);

      p_hs(); p_dec(); p_exi(); p_awb(1'b0); p_fet();
      hs(32'h2022_0005);
      tick(4);

      mem_ready = 1'b1;
      p_hs(); p_dec(); p_maddr(); p_mrd(); p_mwb(); p_fet();
      hs(32'h8C22_0004);
      tick(5);
      mem_ready = 1'b0;

      // lw, memory stalls 3 cycles; ready arrives on the cycle the timeout would fire
      p_hs(); p_dec(); p_maddr(); p_mrd(); p_mrd(); p_mrd(); p_mrd(); p_mwb(); p_fet();
      hs(32'h8C22_0004);
      tick(5);
      mem_ready = 1'b1;
      tick(1);
      mem_ready = 1'b0;
      tick(2);

      mem_ready = 1'b1;
      p_hs(); p_dec(); p_maddr(); p_mwr(); p_fet();
      hs(32'hAC22_0004);
      tick(4);
      mem_ready = 1'b0;

      p_hs(); p_dec(); p_maddr(); p_mwr(); p_mwr(); p_mwr(); p_mwr(); p_ill(); p_fet();
      hs(32'hAC22_0004);
      tick(8);

      alu_zero = 1'b1;
      p_hs(); p_dec(); p_br(1'b1); p_fet();
      hs(32'h1022_0003);
      tick(3);
      alu_zero = 1'b0;
      p_hs(); p_dec(); p_br(1'b0); p_fet();
      hs(32'h1022_0003);
      tick(3);

      // reset asserted mid-load: strobes must fall without a clock edge
      p_hs(); p_dec(); p_maddr(); p_mrd();
      hs(32'h8C22_0004);
      tick(2);
      @(negedge clk); #2 rst_n = 1'b0;
      #1 chk("async_drop_mem_read", 32'(mem_read), 32'd0);
      chk("async_reset_outputs", 32'(cur_vec()), 32'(RST_V));
      repeat (2) @(negedge clk);
      #1 rst_n = 1'b1;
      #1 chk("idle_after_mid_reset", 32'(cur_vec()), 32'(RST_V));
      @(posedge clk); #1 chk("ready_after_mid_reset", 32'(instr_ready), 32'd1);

      p_hs(); p_dec(); p_exr(ALU_OR); p_awb(1'b1); p_fet();
      hs(32'h0022_1825);
      tick(4);

      chk("scoreboard_drained", 32'(sbq.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
